pll_lock_ctrl: RTL and testbench

Reset-sequencing controller for the 24 MHz `refclk` domain. It drives the PLL's active-high `reset` input and consumes the PLL's `extlock` output. It holds the PLL in reset after power-up, waits for lock with a timeout and bounded retries, and requires lock to be stable before releasing the synchronous system reset. It re-sequences on lock loss or on software request, and reports hard failure.

---
 rtl/pll_lock_ctrl.sv | 91 +++++++++
 tb/tb_pll_lock_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset sequencer with lock timeout, bounded retries and stable-lock gating of the system reset
module pll_lock_ctrl #(
    parameter int PWRUP_CYCLES        = 240,
    parameter int LOCK_STABLE_CYCLES  = 2400,
    parameter int LOCK_TIMEOUT_CYCLES = 24000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               refclk,
    input  logic                               reset_n,
    input  logic                               extlock,
    input  logic                               relock_req,
    output logic                               pll_reset,
    output logic                               sys_rst_n,
    output logic                               locked,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);
    localparam int RW   = $clog2(MAX_RETRIES + 1);
    localparam int MAX1 = PWRUP_CYCLES > LOCK_STABLE_CYCLES ? PWRUP_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAXC = MAX1 > LOCK_TIMEOUT_CYCLES ? MAX1 : LOCK_TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PWR_END = CW'(PWRUP_CYCLES - 1);
    localparam logic [CW-1:0] STB_END = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_END  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry_n;
    logic          sync1, lock_s;

    // outputs are decoded from state_n so they switch on the same edge as the state
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            lock_s    <= 1'b0;
            state     <= PLL_RST;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            sync1     <= extlock;
            lock_s    <= sync1;
            state     <= state_n;
            cnt       <= (state_n != state) ? '0 : cnt + 1'b1;
            retry_cnt <= retry_n;
            pll_reset <= (state_n == PLL_RST) || (state_n == FAIL);
            sys_rst_n <= state_n == RUN;
            locked    <= state_n == RUN;
            fail      <= state_n == FAIL;
        end
    end

    always_comb begin
        state_n = state;
        retry_n = retry_cnt;
        case (state)
            PLL_RST:   if (cnt == PWR_END) state_n = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) state_n = STABLE;
                else if (cnt == TO_END) begin
                    if (retry_cnt == R_MAX) state_n = FAIL;
                    else begin
                        retry_n = retry_cnt + 1'b1;
                        state_n = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) state_n = WAIT_LOCK;
                else if (cnt == STB_END) begin
                    state_n = RUN;
                    retry_n = '0;
                end
            end
            RUN:       if (!lock_s || relock_req) state_n = PLL_RST;
            FAIL: begin
                if (relock_req) begin
                    state_n = PLL_RST;
                    retry_n = '0;
                end
            end
            default:   state_n = PLL_RST;
        endcase
    end
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed vector table plus hand sequences for pll_lock_ctrl
module tb_pll_lock_ctrl;
    localparam int P = 4, S = 8, T = 20, M = 2;

    logic       refclk = 1'b0, reset_n = 1'b1, extlock = 1'b0, relock_req = 1'b0, clk_en = 1'b1;
    logic       pll_reset, sys_rst_n, locked, fail;
    logic [1:0] retry_cnt;
    int         checks = 0, errors = 0;

    typedef struct {
        bit         rst;
        bit         ext;
        bit         req;
        int         n;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    pll_lock_ctrl #(
        .PWRUP_CYCLES(P), .LOCK_STABLE_CYCLES(S), .LOCK_TIMEOUT_CYCLES(T), .MAX_RETRIES(M)
    ) dut (
        .refclk(refclk), .reset_n(reset_n), .extlock(extlock), .relock_req(relock_req),
        .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .locked(locked), .fail(fail),
        .retry_cnt(retry_cnt)
    );

    always #5 if (clk_en) refclk = ~refclk;

    // expected {pll_reset, sys_rst_n, locked, fail, retry_cnt} per visible state
    function automatic logic [5:0] pr(int r); return {4'b1000, r[1:0]}; endfunction
    function automatic logic [5:0] wt(int r); return {4'b0000, r[1:0]}; endfunction
    function automatic logic [5:0] rn(int r); return {4'b0110, r[1:0]}; endfunction
    function automatic logic [5:0] fl(int r); return {4'b1001, r[1:0]}; endfunction

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {pll_reset, sys_rst_n, locked, fail, retry_cnt};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: {pll_reset,sys_rst_n,locked,fail,retry_cnt} got %b required %b", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic add(input bit rst, input bit ext, input bit req, input int n, input logic [5:0] e);
        tbl.push_back('{rst, ext, req, n, e});
    endtask

    task automatic do_reset(input bit ext_v);
        clk_en     = 1'b1;
        reset_n    = 1'b0;
        extlock    = ext_v;
        relock_req = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic async_chk(input string name);
        @(negedge refclk);
        clk_en = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check(name, pr(0));
    endtask

    initial begin
        // clean bring-up; relock_req must be ignored in PLL_RST and STABLE
        add(0, 0, 1,  3, pr(0));
        add(0, 0, 0,  1, wt(0));
        add(0, 0, 0,  2, wt(0));
        add(0, 1, 0, 10, wt(0));
        add(0, 1, 0,  1, rn(0));
        // lock loss in RUN, then re-acquire
        add(0, 0, 0,  2, rn(0));
        add(0, 0, 0,  1, pr(0));
        add(0, 1, 0,  3, pr(0));
        add(0, 1, 0,  1, wt(0));
        add(0, 1, 0,  1, wt(0));
        add(0, 1, 1,  7, wt(0));
        add(0, 1, 0,  1, rn(0));
        // relock request in RUN
        add(0, 1, 1,  1, pr(0));
        add(0, 1, 0,  4, wt(0));
        add(0, 1, 0,  1, wt(0));
        add(0, 1, 0,  7, wt(0));
        add(0, 1, 0,  1, rn(0));
        // relock request together with lock loss: a single PLL_RST entry
        add(0, 0, 0,  2, rn(0));
        add(0, 0, 1,  1, pr(0));
        add(0, 1, 0,  3, pr(0));
        add(0, 1, 0,  1, wt(0));
        // retry then fail; relock_req ignored in WAIT_LOCK
        add(1, 0, 0,  3, pr(0));
        add(0, 0, 0,  1, wt(0));
        add(0, 0, 1, 19, wt(0));
        add(0, 0, 0,  1, pr(1));
        add(0, 0, 0,  4, wt(1));
        add(0, 0, 0, 20, pr(2));
        add(0, 0, 0,  4, wt(2));
        add(0, 0, 0, 19, wt(2));
        add(0, 0, 0,  1, fl(2));
        add(0, 0, 0, 30, fl(2));
        // recovery from FAIL, one more retry, then RUN clears retry_cnt
        add(0, 0, 1,  1, pr(0));
        add(0, 0, 0,  4, wt(0));
        add(0, 0, 0, 20, pr(1));
        add(0, 1, 0,  4, wt(1));
        add(0, 1, 0,  1, wt(1));
        add(0, 1, 0,  7, wt(1));
        add(0, 1, 0,  1, rn(0));
        // lock arriving on the timeout cycle wins, no retry consumed
        add(0, 0, 0,  3, pr(0));
        add(0, 0, 0,  4, wt(0));
        add(0, 0, 0, 17, wt(0));
        add(0, 1, 0,  3, wt(0));
        add(0, 1, 0,  7, wt(0));
        add(0, 1, 0,  1, rn(0));

        #1 reset_n = 1'b0;
        step(2);
        check("reset_values", pr(0));
        reset_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset(tbl[i].ext);
            extlock    = tbl[i].ext;
            relock_req = tbl[i].req;
            step(tbl[i].n);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
        relock_req = 1'b0;

        async_chk("async_in_run");

        // one-cycle extlock dropout in STABLE restarts the stability count
        do_reset(1'b1);
        step(4);
        check("unstable_wait", wt(0));
        step(1);
        check("unstable_stable", wt(0));
        step(3);
        extlock = 1'b0;
        step(1);
        extlock = 1'b1;
        step(2);
        check("unstable_drop", wt(0));
        step(2);
        check("unstable_no_early_run", wt(0));
        step(6);
        check("unstable_before_run", wt(0));
        step(1);
        check("unstable_run", rn(0));

        do_reset(1'b1);
        step(5);
        check("mid_stable", wt(0));
        async_chk("async_in_stable");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
